// File: rtl/seg7_pkg.sv
// Shared constants and the hex glyph table for the
// multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int SEG_W      = 7;
  localparam int MAX_DIGITS = 8;

  // Lit-low glyphs, bit6..bit0 = g,f,e,d,c,b,a.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(
    input logic [3:0] nib
  );
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to segment pattern decoder with selectable
// output polarity.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o
);

  // Table is stored lit-low; flip it for lit-high panels.
  always_comb begin
    seg_o = hex_to_seg(nib_i);
    if (ACTIVE_LOW == 0) seg_o = ~seg_o;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with
// blanking, dead cycle, enable and frame pulse.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    enable_i,
  output logic [SEG_W-1:0]        seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  localparam logic SEG_OFF_B = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_OFF_B  = (AN_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF =
    {SEG_W{SEG_OFF_B}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{AN_OFF_B}};

  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg7_scan_driver: CLK_DIV must be >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS)
  begin : g_bad_num
    $error("seg7_scan_driver: NUM_DIGITS out of range");
  end

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic                    zero_run;
  logic [SEG_W-1:0]        dec_seg;
  logic [NUM_DIGITS-1:0]   onehot;

  // Pick the active digit and whether it is a leading zero.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (val_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q) begin
        nib       = val_q[4*i +: 4];
        dp_sel    = dps_q[i];
        blank_sel = (BLANK_LEADING != 0) && (i > 0)
                    && zero_run;
      end
    end
  end

  seg7_hex_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // Shadow capture, prescaler and digit scan sequencing.
  always_comb begin
    val_d   = val_q;
    dps_d   = dps_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (load_i) begin
      val_d = value_i;
      dps_d = dp_i;
    end
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      frame_d = (idx_q == IDX_MAX);
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Next output levels; slot start is a dark dead cycle.
  always_comb begin
    onehot = NUM_DIGITS'(1) << idx_q;
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    dpo_d  = SEG_OFF_B;
    if (enable_i && cnt_q != '0) begin
      an_d  = AN_OFF ^ onehot;
      seg_d = blank_sel ? SEG_OFF : dec_seg;
      dpo_d = SEG_OFF_B ^ dp_sel;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      dps_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      dpo_q   <= SEG_OFF_B;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      dps_q   <= dps_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dpo_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver
// against a cycle-count based behavioural model.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } out_t;

  logic [6:0] TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        en;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b;
  logic       an_c;
  logic       fr_a, fr_b, fr_c;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut_a (
    .clk(clk), .rst(rst), .value_i(value), .dp_i(dp),
    .load_i(load), .enable_i(en), .seg_o(seg_a),
    .dp_o(dp_a), .an_o(an_a), .frame_o(fr_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(0), .BLANK_LEADING(0)
  ) dut_b (
    .clk(clk), .rst(rst), .value_i(value), .dp_i(dp),
    .load_i(load), .enable_i(en), .seg_o(seg_b),
    .dp_o(dp_b), .an_o(an_b), .frame_o(fr_b)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(1), .CLK_DIV(3), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut_c (
    .clk(clk), .rst(rst), .value_i(value[3:0]),
    .dp_i(dp[0]), .load_i(load), .enable_i(en),
    .seg_o(seg_c), .dp_o(dp_c), .an_o(an_c),
    .frame_o(fr_c)
  );

  // Expected outputs from the cycle index since reset.
  function automatic out_t model(
    input int n, input int d, input bit sal,
    input bit aal, input bit bl, input int cyc,
    input logic [15:0] val, input logic [3:0] dpv,
    input logic e
  );
    out_t r;
    int p, k;
    logic [7:0]  amask, on;
    logic [6:0]  lit;
    logic        dl;
    logic [15:0] vm;
    amask = 8'((1 << n) - 1);
    vm = (n >= 4) ? val : 16'(val & ((1 << (4*n)) - 1));
    p = cyc % d;
    k = (cyc / d) % n;
    r.frame = (p == d - 1) && (k == n - 1);
    on = 8'h00; lit = 7'h00; dl = 1'b0;
    if (e && p != 0) begin
      on = 8'(1 << k);
      if (bl && k > 0 && (vm >> (4*k)) == 16'h0)
        lit = 7'h00;
      else
        lit = ~TAB[vm[4*k +: 4]];
      dl = dpv[k];
    end
    r.an  = aal ? (~on & amask) : on;
    r.seg = sal ? ~lit : lit;
    r.dp  = sal ? ~dl : dl;
    return r;
  endfunction

  function automatic out_t off_val(
    input int n, input bit sal, input bit aal
  );
    out_t r;
    r.an    = aal ? 8'((1 << n) - 1) : 8'h00;
    r.seg   = sal ? 7'h7F : 7'h00;
    r.dp    = sal;
    r.frame = 1'b0;
    return r;
  endfunction

  out_t        e_a, e_b, e_c;
  int          mcyc = 0;
  logic [15:0] sh_v = '0;
  logic [3:0]  sh_d = '0;
  bit          mvalid = 0;

  always @(posedge clk) begin
    if (rst) begin
      e_a = off_val(4, 1, 1);
      e_b = off_val(4, 0, 0);
      e_c = off_val(1, 1, 1);
      mcyc = 0; sh_v = '0; sh_d = '0;
    end else begin
      e_a = model(4, 4, 1, 1, 1, mcyc, sh_v, sh_d, en);
      e_b = model(4, 4, 0, 0, 0, mcyc, sh_v, sh_d, en);
      e_c = model(1, 3, 1, 1, 1, mcyc, sh_v, sh_d, en);
      if (load) begin sh_v = value; sh_d = dp; end
      mcyc++;
    end
    mvalid = 1;
  end

  task automatic chk_out(
    input string nm, input out_t act, input out_t exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got an=%h seg=%h dp=%b fr=%b want an=%h seg=%h dp=%b fr=%b",
        nm, $time, act.an, act.seg, act.dp, act.frame,
        exp.an, exp.seg, exp.dp, exp.frame);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk_out("model_a",
        '{an: {4'h0, an_a}, seg: seg_a, dp: dp_a,
          frame: fr_a}, e_a);
      chk_out("model_b",
        '{an: {4'h0, an_b}, seg: seg_b, dp: dp_b,
          frame: fr_b}, e_b);
      chk_out("model_c",
        '{an: {7'h0, an_c}, seg: seg_c, dp: dp_c,
          frame: fr_c}, e_c);
    end
  end

  task automatic lit(
    input string nm, input int act, input int exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_frame(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fr_a && n < 40);
    at = tb_cyc;
    if (!fr_a) lit("frame_timeout", 0, 1);
  endtask

  task automatic wait_an(
    input bit use_b, input logic [3:0] pat
  );
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((use_b ? an_b : an_a) != pat && n < 40);
    if ((use_b ? an_b : an_a) != pat)
      lit("anode_timeout", int'(use_b ? an_b : an_a),
          int'(pat));
  endtask

  task automatic load_val(
    input logic [15:0] v, input logic [3:0] d
  );
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  int t1, t2;

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0;
    value = '0; dp = '0;
    repeat (3) begin
      @(negedge clk);
      lit("rst_an", an_a, 'hF);
      lit("rst_seg", seg_a, 'h7F);
      lit("rst_dp", dp_a, 1);
      lit("rst_frame", fr_a, 0);
      lit("rst_an_b", an_b, 0);
      lit("rst_seg_b", seg_b, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    lit("post_rst_an", an_a, 'hF);
    lit("post_rst_frame", fr_a, 0);

    en = 1'b1;
    load_val(16'h12AF, 4'b0100);
    wait_frame(t1);
    wait_an(0, 4'b1110);
    lit("d0_seg", seg_a, 'h0E);
    lit("d0_dp", dp_a, 1);
    wait_an(0, 4'b1101);
    lit("d1_seg", seg_a, 'h08);
    wait_an(0, 4'b1011);
    lit("d2_seg", seg_a, 'h24);
    lit("d2_dp", dp_a, 0);
    wait_an(0, 4'b0111);
    lit("d3_seg", seg_a, 'h79);

    wait_frame(t1);
    @(negedge clk);
    lit("frame_width", fr_a, 0);
    wait_frame(t2);
    lit("frame_period", t2 - t1, 16);

    load_val(16'h0005, 4'b0000);
    wait_frame(t1);
    wait_an(0, 4'b1101);
    lit("blank_d1", seg_a, 'h7F);
    wait_an(0, 4'b0111);
    lit("blank_d3", seg_a, 'h7F);
    wait_an(0, 4'b1110);
    lit("blank_d0", seg_a, 'h12);

    load_val(16'h0000, 4'b0000);
    wait_frame(t1);
    wait_an(0, 4'b1110);
    lit("zero_d0", seg_a, 'h40);

    load_val(16'h0008, 4'b0000);
    wait_frame(t1);
    wait_an(1, 4'b0001);
    lit("pos_d0_seg", seg_b, 'h7F);

    wait_frame(t1);
    @(negedge clk);
    @(negedge clk);
    value = 16'hFFFF; dp = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    lit("midload_an", an_a, 'hE);
    lit("midload_seg", seg_a, 'h0E);
    en = 1'b0;
    @(negedge clk);
    lit("dis_an", an_a, 'hF);
    wait_frame(t1);
    lit("dis_frame", fr_a, 1);

    for (int i = 0; i < 900; i++) begin
      value = 16'($urandom >> (4 * $urandom_range(0, 4)));
      dp    = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      rst   = (i == 400 || i == 401 ||
               $urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
